// File: rtl/mlsu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mlsu_pkg
// Brief    : Shared types and helpers for the MLSU request pre-decoder.
// Revision : 1.0
// ============================================================================
package mlsu_pkg;

  localparam int unsigned MLSU_ADDR_W = 64;
  localparam int unsigned MLSU_TILE_W = 8;
  localparam int unsigned MLSU_ID_W   = 4;

  localparam logic [1:0] c_mop_row     = 2'b00;
  localparam logic [1:0] c_mop_col     = 2'b01;
  localparam logic [1:0] c_mop_bcast   = 2'b10;
  localparam logic [1:0] c_mop_illegal = 2'b11;

  // Bit position equals the mop encoding, so a decoded mode is simply 1 << mop.
  typedef enum logic [2:0] {
    M_MODE_ROW   = 3'b001,
    M_MODE_COL   = 3'b010,
    M_MODE_BCAST = 3'b100
  } m_mode_oh_e;

  typedef struct packed {
    logic [MLSU_ID_W-1:0]   id;
    m_mode_oh_e             mode;
    logic [MLSU_ADDR_W-1:0] addr;
    logic [MLSU_TILE_W-1:0] row_idx;
    logic                   last;
    logic [1:0]             sew;
    logic [3:0]             md;
    logic                   is_load;
    logic                   vm;
  } mlsu_predec_row_t;

  function automatic logic [2:0] mop_to_mode_oh(input logic [1:0] mop);
    logic [2:0] mode;
    case (mop)
      c_mop_row:   mode = M_MODE_ROW;
      c_mop_col:   mode = M_MODE_COL;
      c_mop_bcast: mode = M_MODE_BCAST;
      default:     mode = 3'b000;
    endcase
    return mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlsu_tile_predecoder_queue_flow.sv
`default_nettype none
// ============================================================================
// Module   : QueueFlow
// Brief    : Registered FIFO (no fall-through) with synchronous flush.
// Revision : 1.0
// ============================================================================
module QueueFlow #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic enq_valid_i,
  output logic enq_ready_o,
  input  T     enq_data_i,
  output logic deq_valid_o,
  input  logic deq_ready_i,
  output T     deq_data_o
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

  T                   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_full;
  logic w_enq_fire;
  logic w_deq_fire;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_w'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_full      = (r_count == c_cnt_w'(DEPTH));
  assign deq_valid_o = (r_count != '0);
  assign deq_data_o  = r_mem[r_rd_ptr];
  // A dequeue in the same cycle frees the slot, so a full queue still accepts.
  assign enq_ready_o = !w_full || deq_ready_i;
  assign w_enq_fire  = enq_valid_i && enq_ready_o;
  assign w_deq_fire  = deq_valid_o && deq_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) begin
        r_mem[r_wr_ptr] <= enq_data_i;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_deq_fire) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlsu_tile_predecoder.sv
`default_nettype none
// ============================================================================
// Module   : mlsu_tile_predecoder
// Brief    : Expands one matrix load/store request into per-row requests.
// Revision : 1.0
// ============================================================================
module mlsu_tile_predecoder
  import mlsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned TILE_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ID_W-1:0]   req_id_i,
  input  logic [1:0]        req_mop_i,
  input  logic [ADDR_W-1:0] req_base_addr_i,
  input  logic [ADDR_W-1:0] req_stride_i,
  input  logic [1:0]        req_sew_i,
  input  logic [TILE_W-1:0] req_tile_i,
  input  logic [3:0]        req_md_i,
  input  logic              req_is_load_i,
  input  logic              req_vm_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ID_W-1:0]   out_id_o,
  output logic [2:0]        out_mode_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [TILE_W-1:0] out_row_idx_o,
  output logic              out_last_o,
  output logic [1:0]        out_sew_o,
  output logic [3:0]        out_md_o,
  output logic              out_is_load_o,
  output logic              out_vm_o,
  output logic              err_valid_o,
  output logic [ID_W-1:0]   err_id_o,
  output logic              busy_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GEN  = 1'b1;

  // Same fields as mlsu_predec_row_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [2:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [TILE_W-1:0] row_idx;
    logic              last;
    logic [1:0]        sew;
    logic [3:0]        md;
    logic              is_load;
    logic              vm;
  } row_t;

  logic [0:0]        r_state;
  logic [ID_W-1:0]   r_id;
  logic [1:0]        r_mop;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [1:0]        r_sew;
  logic [3:0]        r_md;
  logic              r_is_load;
  logic              r_vm;
  logic [TILE_W-1:0] r_rows_left;
  logic [TILE_W-1:0] r_idx;
  logic              r_err_valid;
  logic [ID_W-1:0]   r_err_id;

  logic              w_enq_valid;
  logic              w_enq_ready;
  logic              w_enq_fire;
  logic              w_last;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr_step;
  row_t              w_enq_row;
  row_t              w_deq_row;

  assign w_enq_valid = (r_state == S_GEN);
  assign w_enq_fire  = w_enq_valid && w_enq_ready;
  assign w_last      = (r_rows_left == TILE_W'(1));
  assign req_ready_o = !flush_i &&
                       ((r_state == S_IDLE) || ((r_state == S_GEN) && w_last && w_enq_ready));
  assign w_accept    = req_valid_i && req_ready_o;

  always_comb begin
    w_addr_step = '0;
    case (r_mop)
      c_mop_row: w_addr_step = r_stride;
      c_mop_col: w_addr_step = ADDR_W'(1) << r_sew;
      default:   w_addr_step = '0;
    endcase
  end

  always_comb begin
    w_enq_row         = '0;
    w_enq_row.id      = r_id;
    w_enq_row.mode    = mop_to_mode_oh(r_mop);
    w_enq_row.addr    = r_addr;
    w_enq_row.row_idx = r_idx;
    w_enq_row.last    = w_last;
    w_enq_row.sew     = r_sew;
    w_enq_row.md      = r_md;
    w_enq_row.is_load = r_is_load;
    w_enq_row.vm      = r_vm;
  end

  // An accept on the final enqueue overrides the return to idle so the next tile follows without a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_mop       <= '0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_sew       <= '0;
      r_md        <= '0;
      r_is_load   <= 1'b0;
      r_vm        <= 1'b0;
      r_rows_left <= '0;
      r_idx       <= '0;
      r_err_valid <= 1'b0;
      r_err_id    <= '0;
    end else if (flush_i) begin
      r_state     <= S_IDLE;
      r_rows_left <= '0;
      r_idx       <= '0;
      r_err_valid <= 1'b0;
    end else begin
      r_err_valid <= 1'b0;
      if (w_enq_fire) begin
        r_addr      <= r_addr + w_addr_step;
        r_rows_left <= r_rows_left - 1'b1;
        r_idx       <= r_idx + 1'b1;
        if (w_last) r_state <= S_IDLE;
      end
      if (w_accept) begin
        r_id      <= req_id_i;
        r_mop     <= req_mop_i;
        r_addr    <= req_base_addr_i;
        r_stride  <= req_stride_i;
        r_sew     <= req_sew_i;
        r_md      <= req_md_i;
        r_is_load <= req_is_load_i;
        r_vm      <= req_vm_i;
        r_idx     <= '0;
        if (req_mop_i == c_mop_illegal) begin
          r_err_valid <= 1'b1;
          r_err_id    <= req_id_i;
          r_rows_left <= '0;
        end else if (req_tile_i == '0) begin
          r_rows_left <= '0;
        end else begin
          r_rows_left <= req_tile_i;
          r_state     <= S_GEN;
        end
      end
    end
  end

  QueueFlow #(
    .T     (row_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .enq_valid_i (w_enq_valid),
    .enq_ready_o (w_enq_ready),
    .enq_data_i  (w_enq_row),
    .deq_valid_o (out_valid_o),
    .deq_ready_i (out_ready_i),
    .deq_data_o  (w_deq_row)
  );

  assign out_id_o      = w_deq_row.id;
  assign out_mode_o    = w_deq_row.mode;
  assign out_addr_o    = w_deq_row.addr;
  assign out_row_idx_o = w_deq_row.row_idx;
  assign out_last_o    = w_deq_row.last;
  assign out_sew_o     = w_deq_row.sew;
  assign out_md_o      = w_deq_row.md;
  assign out_is_load_o = w_deq_row.is_load;
  assign out_vm_o      = w_deq_row.vm;
  assign err_valid_o   = r_err_valid;
  assign err_id_o      = r_err_id;
  assign busy_o        = (r_state == S_GEN) || out_valid_o;

endmodule
`default_nettype wire
